// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared state encoding, AHB response codes and slave-select width helper.
package apb_bridge_pkg;

    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;

    localparam logic OKAY  = 1'b0;
    localparam logic ERROR = 1'b1;

    // A single slave still needs a 1-bit index field.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: combinational slave decode of an AHB address.
//   i_addr : transfer address
//   o_sel  : one-hot slave select, all zero on a miss
//   o_miss : slave index field names a slave that does not exist
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 3,
    parameter int SEL_LSB = 24
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_sel,
    output logic               o_miss
);

    localparam int SEL_W = sel_w(NUM_SLV);

    logic [SEL_W-1:0] w_idx;
    logic             w_unused;

    assign w_idx    = i_addr[SEL_LSB +: SEL_W];
    assign o_miss   = 32'(w_idx) >= NUM_SLV;
    // Only the index field matters here; the rest of the address is routed by the top.
    assign w_unused = ^i_addr;

    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) o_sel[i] = 32'(w_idx) == i;
    end

endmodule

// File: rtl/ahb_apb_bridge_ctrl.sv
// ahb_apb_bridge_ctrl: turns single AHB-lite transfers into APB transactions on one of NUM_SLV slaves.
//   clk, rst (async, active-low)
//   AHB side : valid, Hwrite, Haddr, Hwdata in; Hreadyout, Hrdata, Hresp out
//   APB side : Prdata, Pready, Pslverr in; Paddr, Pwdata, Pwrite, Pselx, Penable out
//   Optional : APB_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYC cycles without Pready,
//              answering exactly like a slave error.
module ahb_apb_bridge_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 3,
    parameter int SEL_LSB     = 24,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               Hwrite,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    input  logic [DATA_W-1:0]  Prdata,
    input  logic               Pready,
    input  logic               Pslverr,
    output logic [ADDR_W-1:0]  Paddr,
    output logic [DATA_W-1:0]  Pwdata,
    output logic               Pwrite,
    output logic [NUM_SLV-1:0] Pselx,
    output logic               Penable,
    output logic               Hreadyout,
    output logic [DATA_W-1:0]  Hrdata,
    output logic               Hresp
);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [NUM_SLV-1:0] r_sel;
    logic [NUM_SLV-1:0] w_sel;
    logic               w_miss;
    logic               w_accept;
    logic               w_tmo;

    apb_addr_decode #(
        .ADDR_W (ADDR_W),
        .NUM_SLV(NUM_SLV),
        .SEL_LSB(SEL_LSB)
    ) u_dec (
        .i_addr(Haddr),
        .o_sel (w_sel),
        .o_miss(w_miss)
    );

    assign w_accept = valid && Hreadyout;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // Fires on the wait cycle that would bring the count to TIMEOUT_CYC.
    assign w_tmo = !Pready && (32'(r_cnt) == TIMEOUT_CYC - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (r_state == SETUP)
            r_cnt <= '0;
        else if (r_state == ACCESS && !Pready)
            r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_sel     <= '0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Pwrite    <= 1'b0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Hrdata    <= '0;
            Hresp     <= OKAY;
            Hreadyout <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        Hreadyout <= 1'b0;
                        if (w_miss) begin
                            r_state <= ERR1;
                            Hresp   <= ERROR;
                        end else if (Hwrite) begin
                            // Select is withheld until the write data arrives next cycle.
                            r_state <= WDATA;
                            r_addr  <= Haddr;
                            r_sel   <= w_sel;
                            Pwrite  <= 1'b1;
                        end else begin
                            r_state <= SETUP;
                            Paddr   <= Haddr;
                            Pwrite  <= 1'b0;
                            Pselx   <= w_sel;
                        end
                    end else begin
                        Pselx     <= '0;
                        Penable   <= 1'b0;
                        Hreadyout <= 1'b1;
                        Hresp     <= OKAY;
                    end
                end
                WDATA: begin
                    r_state <= SETUP;
                    Pwdata  <= Hwdata;
                    Paddr   <= r_addr;
                    Pselx   <= r_sel;
                end
                SETUP: begin
                    r_state <= ACCESS;
                    Penable <= 1'b1;
                end
                ACCESS: begin
                    if (Pready || w_tmo) begin
                        Pselx   <= '0;
                        Penable <= 1'b0;
                        if (Pready && !Pslverr) begin
                            r_state   <= IDLE;
                            Hreadyout <= 1'b1;
                            if (!Pwrite) Hrdata <= Prdata;
                        end else begin
                            r_state   <= ERR1;
                            Hresp     <= ERROR;
                            Hreadyout <= 1'b0;
                        end
                    end
                end
                ERR1: begin
                    r_state   <= ERR2;
                    Hresp     <= ERROR;
                    Hreadyout <= 1'b1;
                end
                ERR2: begin
                    r_state   <= IDLE;
                    Hresp     <= OKAY;
                    Hreadyout <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// tb_ahb_apb_bridge_ctrl: vector table, randomized transfers against a transaction model, and corner sequences.
module tb_ahb_apb_bridge_ctrl;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        err;
    } xfer_t;

    typedef struct {
        logic [2:0]  sel;
        int          low;
        int          resp;
        logic [31:0] hrdata;
    } exp_t;

    typedef struct {
        xfer_t x;
        exp_t  e;
    } vec_t;

    typedef struct {
        logic        done;
        logic [2:0]  sel;
        int          low;
        int          resp;
        logic [31:0] addr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic        stable;
        logic        inv;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        Hwrite = 1'b0;
    logic [31:0] Haddr = '0;
    logic [31:0] Hwdata = '0;
    logic [31:0] Prdata = '0;
    logic        Pready = 1'b0;
    logic        Pslverr = 1'b0;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Hreadyout;
    logic [31:0] Hrdata;
    logic        Hresp;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] hr_model = '0;

    always #5 clk = ~clk;

    ahb_apb_bridge_ctrl #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SEL_LSB(24), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .Hwrite(Hwrite), .Haddr(Haddr), .Hwdata(Hwdata),
        .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr), .Paddr(Paddr), .Pwdata(Pwdata),
        .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable), .Hreadyout(Hreadyout),
        .Hrdata(Hrdata), .Hresp(Hresp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectation straight from the protocol rules.
    function automatic exp_t model(input xfer_t x, input logic [31:0] hr_prev);
        exp_t e;
        int   idx;
        logic miss;
        idx      = int'(x.addr[25:24]);
        miss     = idx >= 3;
        e.sel    = miss ? 3'b000 : 3'(1 << idx);
        e.low    = miss ? 1 : (x.w ? 3 : 2) + x.waits + (x.err ? 1 : 0);
        e.resp   = (miss || x.err) ? 2 : 0;
        e.hrdata = (!miss && !x.err && !x.w) ? x.prdata : hr_prev;
        return e;
    endfunction

    task automatic run_xfer(input xfer_t x, output res_t r);
        int   acc;
        logic snap;
        r.done = 1'b0; r.sel = '0; r.low = 0; r.resp = 0; r.addr = '0;
        r.pwrite = 1'b0; r.pwdata = '0; r.stable = 1'b1; r.inv = 1'b1;
        acc = 0;
        snap = 1'b0;
        valid = 1'b1; Hwrite = x.w; Haddr = x.addr; Hwdata = $urandom;
        Prdata = x.prdata; Pready = 1'b0; Pslverr = 1'b0;
        tick();
        valid = 1'b0; Haddr = ~x.addr; Hwdata = x.wdata;
        for (int c = 0; c < 80 && !r.done; c++) begin
            if (Hreadyout && !Hresp) begin
                r.done = 1'b1;
            end else begin
                if (!Hreadyout) r.low++;
                if (Hresp) r.resp++;
                if (Pselx != 0) begin
                    if (!snap) begin
                        snap = 1'b1;
                        r.sel = Pselx; r.addr = Paddr; r.pwrite = Pwrite; r.pwdata = Pwdata;
                    end else if (Pselx != r.sel || Paddr != r.addr || Pwrite != r.pwrite || Pwdata != r.pwdata) begin
                        r.stable = 1'b0;
                    end
                end
                if ((Pselx & (Pselx - 3'd1)) != 0 || (Penable && Pselx == 0)) r.inv = 1'b0;
                Pready = Penable && acc >= x.waits;
                Pslverr = Pready && x.err;
                if (Penable) acc++;
                tick();
                Hwdata = $urandom;
            end
        end
        Pready = 1'b0;
        Pslverr = 1'b0;
    endtask

    task automatic check_xfer(input string tag, input xfer_t x, input exp_t e, input res_t r);
        chk({tag, "_done"}, 32'(r.done), 32'd1);
        chk({tag, "_sel"}, 32'(r.sel), 32'(e.sel));
        chk({tag, "_hready_low"}, r.low, e.low);
        chk({tag, "_hresp_cycles"}, r.resp, e.resp);
        chk({tag, "_hrdata"}, Hrdata, e.hrdata);
        chk({tag, "_invariants"}, 32'(r.inv), 32'd1);
        chk({tag, "_stable"}, 32'(r.stable), 32'd1);
        if (e.sel != 0) begin
            chk({tag, "_paddr"}, r.addr, x.addr);
            chk({tag, "_pwrite"}, 32'(r.pwrite), 32'(x.w));
            if (x.w) chk({tag, "_pwdata"}, r.pwdata, x.wdata);
        end
    endtask

    initial begin
        vec_t  tbl[7];
        xfer_t x;
        exp_t  e;
        res_t  r;
        int    pen;
        logic  got_err;

        tbl[0] = '{x: '{w: 1'b0, addr: 32'h0100_0010, wdata: 32'h0, prdata: 32'hDEAD_BEEF, waits: 0, err: 1'b0},
                   e: '{sel: 3'b010, low: 2, resp: 0, hrdata: 32'hDEAD_BEEF}};
        tbl[1] = '{x: '{w: 1'b1, addr: 32'h0000_0004, wdata: 32'h1234_5678, prdata: 32'h5555_AAAA, waits: 3, err: 1'b0},
                   e: '{sel: 3'b001, low: 6, resp: 0, hrdata: 32'hDEAD_BEEF}};
        tbl[2] = '{x: '{w: 1'b0, addr: 32'h0300_0000, wdata: 32'h0, prdata: 32'h1111_1111, waits: 0, err: 1'b0},
                   e: '{sel: 3'b000, low: 1, resp: 2, hrdata: 32'hDEAD_BEEF}};
        tbl[3] = '{x: '{w: 1'b0, addr: 32'h0200_0008, wdata: 32'h0, prdata: 32'hBAD0_BAD0, waits: 0, err: 1'b1},
                   e: '{sel: 3'b100, low: 3, resp: 2, hrdata: 32'hDEAD_BEEF}};
        tbl[4] = '{x: '{w: 1'b1, addr: 32'h0700_0000, wdata: 32'hCAFE_0000, prdata: 32'h0, waits: 0, err: 1'b0},
                   e: '{sel: 3'b000, low: 1, resp: 2, hrdata: 32'hDEAD_BEEF}};
        tbl[5] = '{x: '{w: 1'b1, addr: 32'h0200_0000, wdata: 32'h0F0F_0F0F, prdata: 32'h0, waits: 1, err: 1'b1},
                   e: '{sel: 3'b100, low: 5, resp: 2, hrdata: 32'hDEAD_BEEF}};
        tbl[6] = '{x: '{w: 1'b0, addr: 32'h00FF_FFFC, wdata: 32'h0, prdata: 32'h0BAD_F00D, waits: 2, err: 1'b0},
                   e: '{sel: 3'b001, low: 4, resp: 0, hrdata: 32'h0BAD_F00D}};

        #1 rst = 1'b0;
        #1;
        chk("rst_paddr", Paddr, 32'h0);
        chk("rst_pwdata", Pwdata, 32'h0);
        chk("rst_pwrite", 32'(Pwrite), 32'h0);
        chk("rst_pselx", 32'(Pselx), 32'h0);
        chk("rst_penable", 32'(Penable), 32'h0);
        chk("rst_hrdata", Hrdata, 32'h0);
        chk("rst_hresp", 32'(Hresp), 32'h0);
        chk("rst_hreadyout", 32'(Hreadyout), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();

        foreach (tbl[i]) begin
            run_xfer(tbl[i].x, r);
            check_xfer($sformatf("vec%0d", i), tbl[i].x, tbl[i].e, r);
        end
        hr_model = tbl[6].e.hrdata;

        for (int n = 0; n < 40; n++) begin
            x.w = 1'($urandom);
            x.addr = $urandom;
            x.addr[25:24] = 2'($urandom_range(0, 3));
            x.wdata = $urandom;
            x.prdata = $urandom;
            x.waits = $urandom_range(0, 5);
            x.err = $urandom_range(0, 5) == 0;
            e = model(x, hr_model);
            run_xfer(x, r);
            check_xfer($sformatf("rnd%0d", n), x, e, r);
            hr_model = e.hrdata;
        end

        // valid held high through the error response must be ignored until IDLE.
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h0300_0040;
        tick();
        Haddr = 32'h0000_0040; Prdata = 32'h7777_1234;
        chk("errv_err1_hresp", 32'(Hresp), 32'h1);
        chk("errv_err1_hready", 32'(Hreadyout), 32'h0);
        tick();
        chk("errv_err2_hresp", 32'(Hresp), 32'h1);
        chk("errv_err2_hready", 32'(Hreadyout), 32'h1);
        tick();
        chk("errv_idle_pselx", 32'(Pselx), 32'h0);
        chk("errv_idle_hresp", 32'(Hresp), 32'h0);
        tick();
        valid = 1'b0;
        chk("errv_accept_pselx", 32'(Pselx), 32'h1);
        Pready = 1'b1;
        tick();
        tick();
        Pready = 1'b0;
        chk("errv_done_hready", 32'(Hreadyout), 32'h1);
        chk("errv_hrdata", Hrdata, 32'h7777_1234);

        // Slave that never answers.
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h0100_0000; Pready = 1'b0;
        tick();
        valid = 1'b0;
        pen = 0;
        got_err = 1'b0;
        for (int c = 0; c < 120 && !got_err; c++) begin
            if (Hresp) got_err = 1'b1;
            else begin
                if (Penable) pen++;
                tick();
            end
        end
`ifdef APB_TIMEOUT_EN
        chk("tmo_err", 32'(got_err), 32'h1);
        chk("tmo_access_cycles", pen, 16);
        chk("tmo_pselx", 32'(Pselx), 32'h0);
        chk("tmo_penable", 32'(Penable), 32'h0);
        tick();
        tick();
        chk("tmo_idle_hresp", 32'(Hresp), 32'h0);
`else
        chk("notmo_no_err", 32'(got_err), 32'h0);
        chk("notmo_penable", 32'(Penable), 32'h1);
        chk("notmo_pselx", 32'(Pselx), 32'h2);
        chk("notmo_waited", 32'(pen >= 100), 32'h1);
        Prdata = 32'h4242_4242;
        Pready = 1'b1;
        tick();
        Pready = 1'b0;
        chk("notmo_done_hready", 32'(Hreadyout), 32'h1);
        chk("notmo_hrdata", Hrdata, 32'h4242_4242);
`endif

        // Reset in ACCESS: asynchronous, no response afterwards.
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h0200_0100; Hwdata = 32'h0;
        tick();
        valid = 1'b0; Hwdata = 32'h9999_0001;
        for (int c = 0; c < 10 && !Penable; c++) tick();
        chk("arst_penable_seen", 32'(Penable), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("arst_pselx", 32'(Pselx), 32'h0);
        chk("arst_penable", 32'(Penable), 32'h0);
        chk("arst_paddr", Paddr, 32'h0);
        chk("arst_pwdata", Pwdata, 32'h0);
        chk("arst_pwrite", 32'(Pwrite), 32'h0);
        chk("arst_hreadyout", 32'(Hreadyout), 32'h1);
        chk("arst_hresp", 32'(Hresp), 32'h0);
        chk("arst_hrdata", Hrdata, 32'h0);
        @(negedge clk) rst = 1'b1;
        Pready = 1'b1;
        Pslverr = 1'b1;
        tick();
        tick();
        chk("arst_after_hresp", 32'(Hresp), 32'h0);
        chk("arst_after_pselx", 32'(Pselx), 32'h0);
        chk("arst_after_hready", 32'(Hreadyout), 32'h1);
        Pready = 1'b0;
        Pslverr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
